// File: rtl/fp_round_pack.sv
// Rounds an unrounded 1-3-4 floating-point word on acceptance and holds results
// in a 2-entry in-order skid buffer, counting saturated words.
module fp_round_pack #(
  parameter int SAT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [2:0]           in_exp,
  input  logic [3:0]           in_sig,
  input  logic                 in_fifth,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_s,
  output logic [2:0]           out_e,
  output logic [3:0]           out_f,
  output logic [SAT_CNT_W-1:0] sat_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  // Returns {saturated, exp, sig}; a carry out of sig renormalises to 1000 and bumps exp.
  function automatic logic [7:0] f_round(input logic [2:0] e, input logic [3:0] f,
                                         input logic fifth);
    logic [7:0] res;
    if (!fifth)
      res = {1'b0, e, f};
    else if (f != 4'b1111)
      res = {1'b0, e, f + 4'd1};
    else if (e != 3'd7)
      res = {1'b0, e + 3'd1, 4'b1000};
    else
      res = {1'b1, 3'd7, 4'b1111};
    return res;
  endfunction

  state_t               r_state;
  logic [7:0]           r_hd;
  logic [7:0]           r_tl;
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  logic [7:0] w_rnd;
  logic [7:0] w_word;
  logic       w_push;
  logic       w_pop;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_rnd     = f_round(in_exp, in_sig, in_fifth);
  assign w_word    = {in_sign, w_rnd[6:0]};

  assign out_s     = r_hd[7];
  assign out_e     = r_hd[6:4];
  assign out_f     = r_hd[3:0];
  assign sat_count = r_sat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_hd      <= 8'd0;
      r_tl      <= 8'd0;
      r_sat_cnt <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_hd    <= w_word;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_hd <= w_word;
          end else if (w_push) begin
            r_tl    <= w_word;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_hd    <= r_tl;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
      // Counter sticks at all-ones rather than wrapping.
      if (w_push && w_rnd[7] && (r_sat_cnt != '1))
        r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
    end
  end

endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 The module SHALL have parameter SAT_CNT_W, default 8, giving the width of the saturation event counter.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, upstream word present.
REQ-005 The module SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-006 The module SHALL have port in_sign, input, 1, sign of the converted value.
REQ-007 The module SHALL have port in_exp, input, 3, unrounded exponent from the linear-to-FP stage.
REQ-008 The module SHALL have port in_sig, input, 4, unrounded significand.
REQ-009 The module SHALL have port in_fifth, input, 1, first discarded bit after the significand (round bit).
REQ-010 The module SHALL have port out_valid, output, 1, rounded word available.
REQ-011 The module SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-012 The module SHALL have port out_s, output, 1, rounded sign.
REQ-013 The module SHALL have port out_e, output, 3, rounded exponent.
REQ-014 The module SHALL have port out_f, output, 4, rounded significand.
REQ-015 The module SHALL have port sat_count, output, SAT_CNT_W, number of accepted words that saturated.

Function
REQ-016 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1, and delivered on a rising edge where out_valid=1 and out_ready=1.
REQ-017 Rounding SHALL be applied to the word at acceptance time: fifth=0 -> exp/sig unchanged; fifth=1 and sig!=4'b1111 -> sig+1, exp unchanged.
REQ-018 Rounding with fifth=1, sig=4'b1111, exp<7 SHALL produce sig=4'b1000 and exp+1.
REQ-019 Rounding with fifth=1, sig=4'b1111, exp=7 SHALL saturate to sig=4'b1111, exp=7 and flag the word as saturated.
REQ-020 Sign SHALL pass through unmodified in all cases.
REQ-021 Rounded words SHALL be held in a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-022 in_ready SHALL equal 1 in EMPTY and ONE and 0 in FULL, and SHALL be a function of state only, not of in_valid or out_ready.
REQ-023 out_valid SHALL equal 1 in ONE and FULL; out_s/out_e/out_f SHALL present the oldest stored word and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE, with the new word presented next cycle; FULL+pop->ONE, with the second word presented next cycle; FULL and no pop->FULL.
REQ-025 Latency SHALL be one cycle: a word accepted at edge N into EMPTY SHALL appear with out_valid=1 after edge N.
REQ-026 A buffered sequence SHALL lose, duplicate or reorder no word under any out_ready pattern.
REQ-027 sat_count SHALL increment by 1 on each accepted saturated word.
REQ-028 sat_count SHALL hold at all-ones instead of wrapping.
REQ-029 Words offered while in_ready=0 SHALL be ignored and SHALL NOT affect sat_count.

Reset
REQ-030 Asserting rst SHALL immediately, without a clock edge, force state EMPTY, out_valid=0, out_s=0, out_e=0, out_f=0, and sat_count=0; in_ready SHALL then read 1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words.
REQ-032 On the first rising edge after rst deasserts, the block SHALL accept a word normally.

Verification
REQ-033 The bench SHALL cover: out_ready=1; push sign=0, exp=3, sig=1010, fifth=1 -> next cycle out_valid=1, out_e=3, out_f=1011.
REQ-034 The bench SHALL cover: push exp=5, sig=1111, fifth=1 -> out_e=6, out_f=1000, sat_count unchanged.
REQ-035 The bench SHALL cover: push sign=1, exp=7, sig=1111, fifth=1 -> out_s=1, out_e=7, out_f=1111, sat_count=1; repeat 300 times with SAT_CNT_W=8 -> sat_count=255.
REQ-036 The bench SHALL cover: out_ready=0; push words A, B, then offer C -> in_ready=0 after B, C not taken; raise out_ready -> A then B delivered in order, A held stable throughout the stall.
REQ-037 The bench SHALL cover: in state ONE, simultaneous push and pop every cycle for 10 words -> state stays ONE, and all 10 words are delivered in order with one-cycle latency.
REQ-038 The bench SHALL cover: in state FULL, assert rst between clock edges -> out_valid=0, in_ready=1, sat_count=0 immediately; a push after deassert is delivered correctly.
